// File: rtl/recip_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : recip_arbiter
// Purpose  : Round-robin scheduler sharing one reciprocal unit among N
//            requesters, with a watchdog that clears a hung unit.
// Revision : 1.0 - initial release
// ============================================================================
module recip_arbiter #(
    parameter int N       = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] x_req,
    output logic [N-1:0]   gnt,
    output logic [N-1:0]   rsp_valid,
    output logic [W-1:0]   rsp_data,
    output logic           rsp_invalid,
    output logic           rsp_timeout,
    output logic           busy,
    output logic [7:0]     err_cnt,
    output logic           start_calc,
    output logic [W-1:0]   x_in,
    input  logic           done,
    input  logic [W-1:0]   x_inv,
    input  logic           invalid,
    output logic           unit_clr
);

    localparam int c_id_w  = $clog2(N);
    localparam int c_cnt_w = $clog2(TIMEOUT);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT - 1);
    localparam logic [N-1:0]       c_one      = {{(N-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              r_state;
    logic [c_id_w-1:0]   r_ptr;
    logic [c_id_w-1:0]   r_id;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [W-1:0]        r_x;
    logic [W-1:0]        r_rsp_data;
    logic                r_rsp_invalid;
    logic                r_rsp_timeout;
    logic [7:0]          r_err_cnt;
    logic [N-1:0]        r_gnt;
    logic [N-1:0]        r_rsp_valid;
    logic                r_start;
    logic                r_unit_clr;

    logic [W-1:0]        w_ops [N];
    logic                w_found;
    logic [c_id_w-1:0]   w_win;
    logic [c_id_w:0]     w_sum;
    logic [c_id_w-1:0]   w_cand;

    for (genvar g = 0; g < N; g++) begin : g_unpack
        assign w_ops[g] = x_req[g*W +: W];
    end

    // Rotating priority: first requester at or after r_ptr, wrapping mod N.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_sum = {1'b0, r_ptr} + (c_id_w+1)'(k);
            if (w_sum >= (c_id_w+1)'(N)) begin
                w_sum = w_sum - (c_id_w+1)'(N);
            end
            w_cand = w_sum[c_id_w-1:0];
            if (!w_found && req[w_cand]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= IDLE;
            r_ptr         <= '0;
            r_id          <= '0;
            r_cnt         <= '0;
            r_x           <= '0;
            r_rsp_data    <= '0;
            r_rsp_invalid <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_err_cnt     <= '0;
            r_gnt         <= '0;
            r_rsp_valid   <= '0;
            r_start       <= 1'b0;
            r_unit_clr    <= 1'b0;
        end else begin
            r_gnt       <= '0;
            r_rsp_valid <= '0;
            r_start     <= 1'b0;
            r_unit_clr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_id    <= w_win;
                        r_x     <= w_ops[w_win];
                        r_gnt   <= c_one << w_win;
                        r_start <= 1'b1;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: begin
                    r_cnt   <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt + c_cnt_w'(1);
                    // done wins over an expiry landing on the same cycle
                    if (done) begin
                        r_rsp_data    <= x_inv;
                        r_rsp_invalid <= invalid;
                        r_rsp_timeout <= 1'b0;
                        r_rsp_valid   <= c_one << r_id;
                        r_state       <= RESP;
                    end else if (r_cnt == c_cnt_last) begin
                        r_rsp_data    <= '0;
                        r_rsp_invalid <= 1'b0;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= c_one << r_id;
                        r_unit_clr    <= 1'b1;
                        if (r_err_cnt != 8'hFF) begin
                            r_err_cnt <= r_err_cnt + 8'd1;
                        end
                        r_state       <= RESP;
                    end
                end
                RESP: begin
                    r_ptr   <= (r_id == c_id_w'(N-1)) ? '0 : r_id + c_id_w'(1);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign gnt         = r_gnt;
    assign rsp_valid   = r_rsp_valid;
    assign rsp_data    = r_rsp_data;
    assign rsp_invalid = r_rsp_invalid;
    assign rsp_timeout = r_rsp_timeout;
    assign busy        = (r_state != IDLE);
    assign err_cnt     = r_err_cnt;
    assign start_calc  = r_start;
    assign x_in        = r_x;
    assign unit_clr    = r_unit_clr;

endmodule
`default_nettype wire

// File: tb/tb_recip_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_recip_arbiter
// Purpose  : Directed self-checking bench for recip_arbiter with a stub unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_recip_arbiter;

    localparam int N       = 4;
    localparam int W       = 32;
    localparam int TIMEOUT = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] x_req;
    logic [N-1:0]   gnt;
    logic [N-1:0]   rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_invalid;
    logic           rsp_timeout;
    logic           busy;
    logic [7:0]     err_cnt;
    logic           start_calc;
    logic [W-1:0]   x_in;
    logic           done = 1'b0;
    logic [W-1:0]   x_inv = '0;
    logic           invalid = 1'b0;
    logic           unit_clr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // stub unit controls; stub_lat == 0 means the unit never answers
    int         stub_lat = 0;
    logic       stub_fn = 1'b0;
    logic [W-1:0] stub_result = '0;
    logic       stub_invalid = 1'b0;
    int         stray_n = 0;
    int         stray_seen = 0;
    int         stub_rem = 0;
    logic       stub_active = 1'b0;

    recip_arbiter #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .req(req), .x_req(x_req), .gnt(gnt),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_invalid(rsp_invalid),
        .rsp_timeout(rsp_timeout), .busy(busy), .err_cnt(err_cnt),
        .start_calc(start_calc), .x_in(x_in), .done(done), .x_inv(x_inv),
        .invalid(invalid), .unit_clr(unit_clr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Stub: done arrives stub_lat cycles after the start_calc cycle.
    always @(negedge clk) begin
        done    = 1'b0;
        invalid = 1'b0;
        if (rst) begin
            stub_active = 1'b0;
        end else begin
            if (stub_active) begin
                stub_rem = stub_rem - 1;
                if (stub_rem == 0) begin
                    done        = 1'b1;
                    x_inv       = stub_fn ? ~x_in : stub_result;
                    invalid     = stub_invalid;
                    stub_active = 1'b0;
                end
            end else if (stray_n != stray_seen) begin
                done       = 1'b1;
                x_inv      = 32'h1234_5678;
                invalid    = 1'b1;
                stray_seen = stray_seen + 1;
            end
            if (start_calc && stub_lat > 0) begin
                stub_active = 1'b1;
                stub_rem    = stub_lat;
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        checks++; if (gnt !== 4'b0 || start_calc !== 1'b0) begin errors++;
            $display("FAIL reset_gnt_start: got gnt=%b start=%b expected 0000/0", gnt, start_calc); end
        checks++; if (rsp_valid !== 4'b0 || unit_clr !== 1'b0) begin errors++;
            $display("FAIL reset_strobes: got rsp_valid=%b unit_clr=%b expected 0000/0", rsp_valid, unit_clr); end
        checks++; if (rsp_data !== 32'h0 || rsp_invalid !== 1'b0 || rsp_timeout !== 1'b0) begin errors++;
            $display("FAIL reset_rsp: got data=%h inv=%b to=%b expected 0/0/0", rsp_data, rsp_invalid, rsp_timeout); end
        checks++; if (busy !== 1'b0 || err_cnt !== 8'd0 || x_in !== 32'h0) begin errors++;
            $display("FAIL reset_misc: got busy=%b err_cnt=%0d x_in=%h expected 0/0/0", busy, err_cnt, x_in); end
    endtask

    task automatic test_single();
        logic [N-1:0] exp_v;
        stub_lat = 9; stub_fn = 1'b0; stub_result = 32'h0000_8000; stub_invalid = 1'b0;
        req = 4'b0001;
        x_req[0 +: W] = 32'h0002_0000;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 1) req = 4'b0;
            exp_v = (k == 11) ? 4'b0001 : 4'b0000;
            checks++; if (gnt !== ((k == 1) ? 4'b0001 : 4'b0000)) begin errors++;
                $display("FAIL single_gnt k=%0d: got %b expected %b", k, gnt, (k == 1) ? 4'b0001 : 4'b0000); end
            checks++; if (start_calc !== (k == 1)) begin errors++;
                $display("FAIL single_start k=%0d: got %b expected %b", k, start_calc, (k == 1)); end
            checks++; if (rsp_valid !== exp_v) begin errors++;
                $display("FAIL single_rsp_valid k=%0d: got %b expected %b", k, rsp_valid, exp_v); end
            if (k == 10) begin
                checks++; if (x_in !== 32'h0002_0000 || busy !== 1'b1) begin errors++;
                    $display("FAIL single_x_in: got x_in=%h busy=%b expected 00020000/1", x_in, busy); end
            end
            if (k == 11) begin
                checks++; if (rsp_data !== 32'h0000_8000 || rsp_invalid !== 1'b0 || rsp_timeout !== 1'b0) begin errors++;
                    $display("FAIL single_rsp: got data=%h inv=%b to=%b expected 00008000/0/0", rsp_data, rsp_invalid, rsp_timeout); end
            end
            if (k == 12) begin
                checks++; if (busy !== 1'b0 || rsp_data !== 32'h0000_8000) begin errors++;
                    $display("FAIL single_hold: got busy=%b data=%h expected 0/00008000", busy, rsp_data); end
            end
        end
    endtask

    task automatic test_fairness();
        logic [W-1:0] ops [N];
        int ngnt, nrsp, gid, last_id, last_rsp_cyc;
        logic [N-1:0] onehot;
        apply_reset();
        stub_lat = 2; stub_fn = 1'b1; stub_invalid = 1'b0;
        for (int i = 0; i < N; i++) begin
            ops[i] = 32'h0001_0000 * (i + 1) + 32'h11 * i;
            x_req[i*W +: W] = ops[i];
        end
        ngnt = 0; nrsp = 0; last_id = 0; last_rsp_cyc = 0;
        @(negedge clk);
        req = 4'b1111;
        for (int c = 0; c < 200 && nrsp < 8; c++) begin
            @(negedge clk);
            if (gnt !== 4'b0) begin
                gid = -1;
                for (int i = 0; i < N; i++) if (gnt[i]) gid = i;
                checks++; if (gid != (ngnt % N)) begin errors++;
                    $display("FAIL fair_order op=%0d: got %0d expected %0d", ngnt, gid, ngnt % N); end
                if (ngnt > 0) begin
                    checks++; if (cyc - last_rsp_cyc != 2) begin errors++;
                        $display("FAIL back_to_back op=%0d: got gap %0d expected 2", ngnt, cyc - last_rsp_cyc); end
                end
                last_id = (gid < 0) ? 0 : gid;
                ngnt++;
                if (ngnt == 8) req = 4'b0;
            end
            if (rsp_valid !== 4'b0) begin
                onehot = '0;
                onehot[last_id] = 1'b1;
                checks++; if (rsp_valid !== onehot) begin errors++;
                    $display("FAIL fair_rsp_valid: got %b expected %b", rsp_valid, onehot); end
                checks++; if (rsp_data !== ~ops[last_id]) begin errors++;
                    $display("FAIL fair_rsp_data: got %h expected %h", rsp_data, ~ops[last_id]); end
                last_rsp_cyc = cyc;
                nrsp++;
            end
        end
        req = 4'b0;
        checks++; if (nrsp != 8 || ngnt != 8) begin errors++;
            $display("FAIL fair_count: got %0d grants %0d responses expected 8/8", ngnt, nrsp); end
        @(negedge clk);
    endtask

    task automatic test_invalid();
        stub_lat = 2; stub_fn = 1'b0; stub_result = 32'h0; stub_invalid = 1'b1;
        req = 4'b0100;
        x_req[2*W +: W] = 32'hFFFF_0000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req = 4'b0;
                checks++; if (gnt !== 4'b0100) begin errors++;
                    $display("FAIL inv_gnt: got %b expected 0100", gnt); end
            end
            checks++; if (rsp_valid !== ((k == 4) ? 4'b0100 : 4'b0000)) begin errors++;
                $display("FAIL inv_rsp_valid k=%0d: got %b expected %b", k, rsp_valid, (k == 4) ? 4'b0100 : 4'b0000); end
            if (k == 4) begin
                checks++; if (rsp_invalid !== 1'b1 || rsp_data !== 32'h0 || rsp_timeout !== 1'b0) begin errors++;
                    $display("FAIL inv_rsp: got inv=%b data=%h to=%b expected 1/0/0", rsp_invalid, rsp_data, rsp_timeout); end
            end
        end
    endtask

    task automatic test_timeout();
        stub_lat = 0;
        req = 4'b0001;
        x_req[0 +: W] = 32'h0003_0000;
        for (int k = 1; k <= 36; k++) begin
            @(negedge clk);
            if (k == 1) req = 4'b0;
            checks++; if (rsp_valid !== ((k == 34) ? 4'b0001 : 4'b0000)) begin errors++;
                $display("FAIL to_rsp_valid k=%0d: got %b expected %b", k, rsp_valid, (k == 34) ? 4'b0001 : 4'b0000); end
            checks++; if (unit_clr !== (k == 34)) begin errors++;
                $display("FAIL to_unit_clr k=%0d: got %b expected %b", k, unit_clr, (k == 34)); end
            if (k == 33) begin
                checks++; if (busy !== 1'b1 || err_cnt !== 8'd0) begin errors++;
                    $display("FAIL to_pre: got busy=%b err_cnt=%0d expected 1/0", busy, err_cnt); end
            end
            if (k == 34) begin
                checks++; if (rsp_timeout !== 1'b1 || rsp_data !== 32'h0 || rsp_invalid !== 1'b0 || err_cnt !== 8'd1) begin errors++;
                    $display("FAIL to_rsp: got to=%b data=%h inv=%b err_cnt=%0d expected 1/0/0/1",
                             rsp_timeout, rsp_data, rsp_invalid, err_cnt); end
            end
        end
        stray_n = stray_n + 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin errors++;
                $display("FAIL stray_done k=%0d: got rsp_valid=%b busy=%b expected 0000/0", k, rsp_valid, busy); end
        end
        checks++; if (rsp_data !== 32'h0 || rsp_timeout !== 1'b1 || rsp_invalid !== 1'b0 || err_cnt !== 8'd1) begin errors++;
            $display("FAIL stray_hold: got data=%h to=%b inv=%b err_cnt=%0d expected 0/1/0/1",
                     rsp_data, rsp_timeout, rsp_invalid, err_cnt); end
    endtask

    task automatic test_done_last();
        stub_lat = 32; stub_fn = 1'b0; stub_result = 32'h0000_4000; stub_invalid = 1'b0;
        req = 4'b0010;
        x_req[1*W +: W] = 32'h0004_0000;
        for (int k = 1; k <= 35; k++) begin
            @(negedge clk);
            if (k == 1) req = 4'b0;
            checks++; if (rsp_valid !== ((k == 34) ? 4'b0010 : 4'b0000) || unit_clr !== 1'b0) begin errors++;
                $display("FAIL last_rsp_valid k=%0d: got %b clr=%b expected %b/0",
                         k, rsp_valid, unit_clr, (k == 34) ? 4'b0010 : 4'b0000); end
            if (k == 34) begin
                checks++; if (rsp_timeout !== 1'b0 || rsp_data !== 32'h0000_4000 || err_cnt !== 8'd1) begin errors++;
                    $display("FAIL last_rsp: got to=%b data=%h err_cnt=%0d expected 0/00004000/1",
                             rsp_timeout, rsp_data, err_cnt); end
            end
        end
    endtask

    task automatic test_reset_mid();
        stub_lat = 0;
        req = 4'b1000;
        x_req[3*W +: W] = 32'h0005_0000;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req = 4'b0;
                checks++; if (gnt !== 4'b1000) begin errors++;
                    $display("FAIL mid_gnt: got %b expected 1000", gnt); end
            end
        end
        rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || gnt !== 4'b0 || rsp_valid !== 4'b0 || start_calc !== 1'b0 || unit_clr !== 1'b0) begin errors++;
            $display("FAIL mid_rst_strobes: got busy=%b gnt=%b rv=%b st=%b clr=%b expected all 0",
                     busy, gnt, rsp_valid, start_calc, unit_clr); end
        checks++; if (rsp_data !== 32'h0 || err_cnt !== 8'd0 || x_in !== 32'h0 || rsp_timeout !== 1'b0 || rsp_invalid !== 1'b0) begin errors++;
            $display("FAIL mid_rst_regs: got data=%h err=%0d x_in=%h to=%b inv=%b expected all 0",
                     rsp_data, err_cnt, x_in, rsp_timeout, rsp_invalid); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        stub_lat = 2; stub_fn = 1'b1; stub_invalid = 1'b0;
        x_req[1*W +: W] = 32'h0006_0000;
        x_req[3*W +: W] = 32'h0007_0000;
        @(negedge clk);
        checks++; if (rsp_valid !== 4'b0 || busy !== 1'b0) begin errors++;
            $display("FAIL mid_no_rsp: got rsp_valid=%b busy=%b expected 0000/0", rsp_valid, busy); end
        req = 4'b1010;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req = 4'b0;
                checks++; if (gnt !== 4'b0010) begin errors++;
                    $display("FAIL mid_ptr0_gnt: got %b expected 0010", gnt); end
            end
            checks++; if (rsp_valid !== ((k == 4) ? 4'b0010 : 4'b0000)) begin errors++;
                $display("FAIL mid_rsp_valid k=%0d: got %b expected %b", k, rsp_valid, (k == 4) ? 4'b0010 : 4'b0000); end
            if (k == 4) begin
                checks++; if (rsp_data !== ~32'h0006_0000) begin errors++;
                    $display("FAIL mid_rsp_data: got %h expected %h", rsp_data, ~32'h0006_0000); end
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        req   = '0;
        x_req = '0;
        test_reset();
        test_single();
        test_fairness();
        test_invalid();
        test_timeout();
        test_done_last();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/recip_arbiter.md
# recip_arbiter

Round-robin scheduler that shares one fixed-point reciprocal unit among N requesters in the watchdog datapath. It accepts one operand at a time and issues a single `start_calc` pulse to the unit. It waits for the unit's `done`, then returns the result, the invalid flag and a timeout flag to the requester that was granted. A watchdog timer bounds the wait; on expiry the block clears the unit and reports the timeout.

## Interface
- `N`, default 4: number of requesters (2..8).
- `W`, default 32: operand/result width (Q16 fixed point).
- `TIMEOUT`, default 32: maximum WAIT cycles before declaring a timeout (≥ 4).

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N  per-requester request level.
- `x_req`  in  N*W  operands; slice i is `x_req[i*W +: W]`, signed.
- `gnt`  out  N  one-hot, 1-cycle grant; the operand is consumed.
- `rsp_valid`  out  N  one-hot, 1-cycle response strobe.
- `rsp_data`  out  W  result, held until the next response.
- `rsp_invalid`  out  1  the unit reported invalid input (x ≤ 0).
- `rsp_timeout`  out  1  the watchdog expired; `rsp_data` = 0.
- `busy`  out  1  high in any state other than IDLE.
- `err_cnt`  out  8  count of timeouts, saturating at 255.
- `start_calc`  out  1  to the unit, 1-cycle pulse.
- `x_in`  out  W  to the unit, the latched operand.
- `done`  in  1  from the unit.
- `x_inv`  in  W  from the unit.
- `invalid`  in  1  from the unit.
- `unit_clr`  out  1  1-cycle clear request; the integrator ORs it into the unit's reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If `req` ≠ 0, select winner `id` = first set bit searching from `ptr` upward with wrap-around (`ptr` = last served + 1 mod N).
  - Latch `x_req` slice `id` into the operand register, then go to ISSUE.
  - If `req` = 0, stay in IDLE.
- ISSUE: `gnt[id]`=1 and `start_calc`=1 for exactly this cycle; clear the watchdog counter; go to WAIT.
- WAIT:
  - Increment the counter each cycle.
  - If `done`=1: capture `x_inv` into `rsp_data` and `invalid` into `rsp_invalid`, clear `rsp_timeout`, go to RESP.
  - Otherwise, if counter = TIMEOUT-1: set `rsp_data`=0, `rsp_invalid`=0, `rsp_timeout`=1, increment `err_cnt` (saturating), go to RESP.
  - `done` takes priority over timeout in the same cycle.
- RESP:
  - `rsp_valid[id]`=1 for one cycle.
  - `unit_clr`=1 for this cycle only if `rsp_timeout`=1.
  - `ptr` ← (`id`+1) mod N; go to IDLE.
- `x_in` holds the latched operand from ISSUE through RESP. It must not change while the unit is busy, because the unit re-reads `x_in` when it asserts `done`.
- `done` seen in IDLE, ISSUE or RESP is ignored: no capture, no strobe.
- A requester may keep `req` high after `gnt`. That is treated as a new request and re-arbitrated in the next IDLE. Requesters must hold `req` and their operand stable until `gnt`.
- Reset, including mid-operation: state goes to IDLE; `ptr`, `id`, counter, operand, `rsp_*`, `err_cnt` go to 0; all strobes go low. No response is issued for an aborted operation.
- Reset value of every output is 0.

## Timing
- Request level seen in IDLE at cycle t:
  - `gnt`/`start_calc` at t+1.
  - WAIT from t+2.
  - `rsp_valid` one cycle after the cycle in which `done` is seen.
- With the reciprocal unit (done 9 cycles after start, i.e. at t+10): `rsp_valid` at t+11 for a valid operand.
- For x ≤ 0 the unit's done arrives at t+3, so `rsp_valid` is at t+4.
- Timeout: `rsp_valid` with `rsp_timeout` at t+2+TIMEOUT.
- Back-to-back operations: next `gnt` no earlier than 2 cycles after `rsp_valid` (RESP→IDLE→ISSUE).
- One operation in flight at a time; throughput is 1 per (latency+3) cycles.

## Test plan
- Single request: `req`=0001, x=0x00020000 (2.0), stub unit with done at start+9 returning 0x00008000 -> `gnt`=0001 at t+1, `start_calc` 1 cycle, `rsp_valid`=0001 at t+11, `rsp_data`=0x00008000, `rsp_invalid`=0, `rsp_timeout`=0.
- Fairness: `req`=1111 held for 8 operations -> grant order 0,1,2,3,0,1,2,3; no index served twice before the others.
- Invalid operand: x=0xFFFF0000 on requester 2, stub done at start+2 with `invalid`=1 -> `rsp_valid`=0100 at t+4, `rsp_invalid`=1, `rsp_data`=0.
- Timeout: stub never asserts `done`, TIMEOUT=32 -> `rsp_valid` with `rsp_timeout`=1 at t+34, `unit_clr` pulse in the same cycle, `err_cnt`=1; a stray `done` arriving later in IDLE is ignored.
- `done` on the last WAIT cycle (counter = TIMEOUT-1) -> normal response, `rsp_timeout`=0, `err_cnt` unchanged.
- Reset asserted during WAIT -> all outputs 0 immediately; no `rsp_valid`; after release, `req`=0010 is served first (`ptr`=0 search).
